// File: rtl/ram_arbiter.sv
// Two-requester round-robin front end for a single-port synchronous-read RAM,
// with a command-driven full-memory clear sequencer.
module ram_arbiter #(
  parameter int AW = 9,
  parameter int DW = 12
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          a_valid,
  input  logic          a_rw,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_wdata,
  input  logic          b_valid,
  input  logic          b_rw,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_wdata,
  output logic          a_ready,
  output logic          b_ready,
  output logic          a_rsp_valid,
  output logic          b_rsp_valid,
  output logic [DW-1:0] rsp_rdata,
  input  logic          clr_start,
  output logic          busy,
  output logic          clr_done,
  output logic          ram_cs,
  output logic          ram_rw,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata
);

  typedef enum logic {S_IDLE = 1'b0, S_CLEAR = 1'b1} state_t;

  state_t        r_state, w_state_nxt;
  logic          r_pri, w_pri_nxt;
  logic [AW-1:0] r_cnt, w_cnt_nxt;
  logic          r_a_rsp_valid, r_b_rsp_valid, r_clr_done;
  logic          w_clr_done_nxt;
  logic          w_grant_a, w_grant_b, w_clear;

  // Next-state, arbitration and clear sequencing; a clear request wins over any grant.
  always_comb begin
    w_state_nxt    = r_state;
    w_pri_nxt      = r_pri;
    w_cnt_nxt      = r_cnt;
    w_clr_done_nxt = 1'b0;
    w_grant_a      = 1'b0;
    w_grant_b      = 1'b0;
    w_clear        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (clr_start) begin
          w_state_nxt = S_CLEAR;
          w_cnt_nxt   = '0;
        end else if (a_valid && (!b_valid || !r_pri)) begin
          w_grant_a = 1'b1;
          w_pri_nxt = 1'b1;
        end else if (b_valid) begin
          w_grant_b = 1'b1;
          w_pri_nxt = 1'b0;
        end else begin
          w_pri_nxt = r_pri;
        end
      end
      S_CLEAR: begin
        w_clear = 1'b1;
        if (r_cnt == {AW{1'b1}}) begin
          w_state_nxt    = S_IDLE;
          w_cnt_nxt      = '0;
          w_clr_done_nxt = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + {{(AW-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // State, priority pointer, clear counter and response/done strobes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_pri         <= 1'b0;
      r_cnt         <= '0;
      r_a_rsp_valid <= 1'b0;
      r_b_rsp_valid <= 1'b0;
      r_clr_done    <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_pri         <= w_pri_nxt;
      r_cnt         <= w_cnt_nxt;
      r_a_rsp_valid <= w_grant_a & a_rw;
      r_b_rsp_valid <= w_grant_b & b_rw;
      r_clr_done    <= w_clr_done_nxt;
    end
  end

  // Grants are combinational, so reset must gate them directly to keep the RAM idle.
  assign a_ready     = ~rst & w_grant_a;
  assign b_ready     = ~rst & w_grant_b;
  assign busy        = (r_state == S_CLEAR);
  assign clr_done    = r_clr_done;
  assign a_rsp_valid = r_a_rsp_valid;
  assign b_rsp_valid = r_b_rsp_valid;
  assign rsp_rdata   = ram_rdata;

  assign ram_cs    = ~rst & (w_grant_a | w_grant_b | w_clear);
  assign ram_rw    = (rst | w_clear) ? 1'b0 :
                     w_grant_b ? b_rw : (w_grant_a & a_rw);
  assign ram_addr  = rst       ? {AW{1'b0}} :
                     w_clear   ? r_cnt :
                     w_grant_b ? b_addr :
                     w_grant_a ? a_addr : {AW{1'b0}};
  assign ram_wdata = rst       ? {DW{1'b0}} :
                     w_grant_b ? b_wdata :
                     w_grant_a ? a_wdata : {DW{1'b0}};

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter (AW=4, DW=8) with a behavioural RAM and a
// response scoreboard filled from a bench-side arbitration/memory model.
module tb_ram_arbiter;
  localparam int AW = 4;
  localparam int DW = 8;

  logic          clk, rst;
  logic          a_valid, a_rw, b_valid, b_rw, clr_start;
  logic [AW-1:0] a_addr, b_addr;
  logic [DW-1:0] a_wdata, b_wdata;
  logic          a_ready, b_ready, a_rsp_valid, b_rsp_valid, busy, clr_done;
  logic          ram_cs, ram_rw;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata, ram_rdata, rsp_rdata;

  ram_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_rw(a_rw), .a_addr(a_addr), .a_wdata(a_wdata),
    .b_valid(b_valid), .b_rw(b_rw), .b_addr(b_addr), .b_wdata(b_wdata),
    .a_ready(a_ready), .b_ready(b_ready),
    .a_rsp_valid(a_rsp_valid), .b_rsp_valid(b_rsp_valid), .rsp_rdata(rsp_rdata),
    .clr_start(clr_start), .busy(busy), .clr_done(clr_done),
    .ram_cs(ram_cs), .ram_rw(ram_rw), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural single-port RAM with registered read
  logic [DW-1:0] mem [16];
  always @(posedge clk) begin
    if (ram_cs) begin
      if (ram_rw) ram_rdata <= mem[ram_addr];
      else        mem[ram_addr] <= ram_wdata;
    end
  end

  typedef struct {logic port; logic [DW-1:0] data; int due;} rsp_t;
  rsp_t          sb[$];
  logic [DW-1:0] m_mem [16];
  logic          m_pri;
  int            cyc = 0;
  int            tests_run = 0;
  int            tests_failed = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Response monitor: pops the scoreboard when a response is due, else expects silence
  always @(negedge clk) begin
    tests_run++;
    if (sb.size() > 0 && sb[0].due == cyc) begin
      if (a_rsp_valid !== (sb[0].port == 1'b0) || b_rsp_valid !== (sb[0].port == 1'b1) ||
          rsp_rdata !== sb[0].data) begin
        tests_failed++;
        $display("FAIL rsp: a_rsp=%b b_rsp=%b rdata=%h, required port %0d rdata %h",
                 a_rsp_valid, b_rsp_valid, rsp_rdata, sb[0].port, sb[0].data);
      end
      void'(sb.pop_front());
    end else if (a_rsp_valid !== 1'b0 || b_rsp_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL spurious_rsp: a_rsp=%b b_rsp=%b, required 0 0", a_rsp_valid, b_rsp_valid);
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // One arbitration cycle: drive, predict grants from the model, update model
  task automatic arb_cycle(input logic av, input logic arw, input logic [AW-1:0] aad,
                           input logic [DW-1:0] awd, input logic bv, input logic brw,
                           input logic [AW-1:0] bad, input logic [DW-1:0] bwd,
                           output logic ega, output logic egb);
    @(negedge clk);
    a_valid = av; a_rw = arw; a_addr = aad; a_wdata = awd;
    b_valid = bv; b_rw = brw; b_addr = bad; b_wdata = bwd;
    clr_start = 1'b0;
    ega = av && (!bv || !m_pri);
    egb = bv && !ega;
    #1;
    if (ega) begin
      m_pri = 1'b1;
      if (arw) sb.push_back('{port: 1'b0, data: m_mem[aad], due: cyc + 1});
      else     m_mem[aad] = awd;
    end else if (egb) begin
      m_pri = 1'b0;
      if (brw) sb.push_back('{port: 1'b1, data: m_mem[bad], due: cyc + 1});
      else     m_mem[bad] = bwd;
    end
  endtask

  task automatic idle_cycles(input int n);
    logic ga, gb;
    for (int i = 0; i < n; i++) arb_cycle(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0, ga, gb);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1; a_valid = 1'b0; b_valid = 1'b0; clr_start = 1'b0;
    m_pri = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic preload(input logic [DW-1:0] val);
    logic ga, gb;
    for (int i = 0; i < 16; i++) arb_cycle(1'b1, 1'b0, 4'(i), val, 1'b0, 1'b0, '0, '0, ga, gb);
  endtask

  // Clear scenario driver; also applies the clear to the memory model
  task automatic run_clear(input logic a_req, input int repulse_at, input int withdraw_at,
                           input int rst_at, output int busy_n, output int done_n,
                           output int rdy_n, output int drv_err, output logic rst_ok,
                           output logic ga_done);
    busy_n = 0; done_n = 0; rdy_n = 0; drv_err = 0; rst_ok = 1'b1; ga_done = 1'b0;
    @(negedge clk);
    clr_start = 1'b1; a_valid = a_req; a_rw = 1'b0; a_addr = '0; a_wdata = 8'h33;
    b_valid = 1'b0;
    #1;
    if (a_ready !== 1'b0) rdy_n++;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      clr_start = (i == repulse_at);
      a_valid   = a_req || (i == withdraw_at);
      a_rw      = !a_req;
      if (i == rst_at) rst = 1'b1;
      #1;
      if (rst) begin
        rst_ok = (busy === 1'b0 && ram_cs === 1'b0 && a_ready === 1'b0 && b_ready === 1'b0);
        for (int j = 0; j < rst_at; j++) m_mem[j] = '0;
        m_pri = 1'b0;
        @(negedge clk);
        rst = 1'b0; a_valid = 1'b0; clr_start = 1'b0;
        for (int j = 0; j < 20; j++) begin
          @(negedge clk);
          #1;
          if (clr_done === 1'b1) done_n++;
          if (busy === 1'b1) busy_n++;
        end
        return;
      end
      if (busy === 1'b1) begin
        busy_n++;
        if (clr_done === 1'b1) done_n++;
        if (a_ready !== 1'b0 || b_ready !== 1'b0) rdy_n++;
        if (ram_cs !== 1'b1 || ram_rw !== 1'b0 || ram_addr !== 4'(i) || ram_wdata !== 8'h00)
          drv_err++;
      end else begin
        if (clr_done === 1'b1) done_n++;
        ga_done = a_ready;
        break;
      end
    end
    for (int j = 0; j < 16; j++) m_mem[j] = '0;
    if (a_req) begin
      m_mem[0] = 8'h33;
      m_pri    = 1'b1;
    end
    @(negedge clk);
    a_valid = 1'b0;
    #1;
    if (clr_done === 1'b1) done_n++;
  endtask

  task automatic test_reset();
    a_valid = 1'b1; a_rw = 1'b1; a_addr = 4'hF; a_wdata = 8'hFF;
    b_valid = 1'b1; b_rw = 1'b0; b_addr = 4'hE; b_wdata = 8'hEE; clr_start = 1'b1;
    #2;
    tests_run++;
    if (a_ready !== 1'b0 || b_ready !== 1'b0 || ram_cs !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_grant: a_ready=%b b_ready=%b ram_cs=%b, required 0 0 0", a_ready, b_ready, ram_cs);
    end
    tests_run++;
    if (ram_rw !== 1'b0 || ram_addr !== 4'h0 || ram_wdata !== 8'h00) begin
      tests_failed++;
      $display("FAIL reset_ram_bus: rw=%b addr=%h wdata=%h, required 0 0 00", ram_rw, ram_addr, ram_wdata);
    end
    tests_run++;
    if (busy !== 1'b0 || clr_done !== 1'b0 || a_rsp_valid !== 1'b0 || b_rsp_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_status: busy=%b clr_done=%b a_rsp=%b b_rsp=%b, required 0 0 0 0",
               busy, clr_done, a_rsp_valid, b_rsp_valid);
    end
    @(negedge clk);
    @(negedge clk);
    a_valid = 1'b0; b_valid = 1'b0; clr_start = 1'b0;
    rst = 1'b0;
    m_pri = 1'b0;
    idle_cycles(1);
    tests_run++;
    if (busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_release_busy: busy=%b, required 0", busy);
    end
  endtask

  task automatic test_contention();
    logic ga, gb;
    arb_cycle(1'b1, 1'b0, 4'd1, 8'h11, 1'b0, 1'b0, '0, '0, ga, gb);
    arb_cycle(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 4'd2, 8'h22, ga, gb);
    pulse_reset();
    for (int i = 0; i < 4; i++) begin
      arb_cycle(1'b1, 1'b1, 4'd1, '0, 1'b1, 1'b1, 4'd2, '0, ga, gb);
      tests_run++;
      if (a_ready !== (i % 2 == 0) || b_ready !== (i % 2 == 1)) begin
        tests_failed++;
        $display("FAIL contention_grant[%0d]: a_ready=%b b_ready=%b, required %b %b",
                 i, a_ready, b_ready, (i % 2 == 0), (i % 2 == 1));
      end
    end
    idle_cycles(2);
    tests_run++;
    if (sb.size() != 0) begin
      tests_failed++;
      $display("FAIL contention_drain: %0d responses outstanding, required 0", sb.size());
    end
  endtask

  task automatic test_a_write_read();
    logic ga, gb;
    arb_cycle(1'b1, 1'b0, 4'd3, 8'h5A, 1'b0, 1'b0, '0, '0, ga, gb);
    tests_run++;
    if (a_ready !== 1'b1 || b_ready !== 1'b0 || ram_cs !== 1'b1 || ram_rw !== 1'b0 ||
        ram_addr !== 4'd3 || ram_wdata !== 8'h5A) begin
      tests_failed++;
      $display("FAIL a_write_drive: ready=%b cs=%b rw=%b addr=%h wdata=%h, required 1 1 0 3 5a",
               a_ready, ram_cs, ram_rw, ram_addr, ram_wdata);
    end
    arb_cycle(1'b1, 1'b1, 4'd3, '0, 1'b0, 1'b0, '0, '0, ga, gb);
    tests_run++;
    if (a_ready !== 1'b1 || ram_rw !== 1'b1 || ram_addr !== 4'd3) begin
      tests_failed++;
      $display("FAIL a_read_drive: ready=%b rw=%b addr=%h, required 1 1 3", a_ready, ram_rw, ram_addr);
    end
    idle_cycles(1);
    tests_run++;
    if (a_rsp_valid !== 1'b1 || b_rsp_valid !== 1'b0 || rsp_rdata !== 8'h5A) begin
      tests_failed++;
      $display("FAIL a_read_rsp: a_rsp=%b b_rsp=%b rdata=%h, required 1 0 5a", a_rsp_valid, b_rsp_valid, rsp_rdata);
    end
    idle_cycles(1);
  endtask

  task automatic test_b_write_no_rsp();
    logic ga, gb;
    arb_cycle(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 4'd9, 8'h77, ga, gb);
    tests_run++;
    if (b_ready !== 1'b1 || a_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL b_write_grant: b_ready=%b a_ready=%b, required 1 0", b_ready, a_ready);
    end
    idle_cycles(1);
    tests_run++;
    if (b_rsp_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL b_write_no_rsp: b_rsp=%b, required 0", b_rsp_valid);
    end
    arb_cycle(1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 4'd9, '0, ga, gb);
    idle_cycles(2);
  endtask

  task automatic test_clear();
    int bn, dn, rn, de;
    logic rok, gd, ga, gb;
    preload(8'hFF);
    run_clear(1'b0, -1, -1, -1, bn, dn, rn, de, rok, gd);
    tests_run++;
    if (bn !== 16 || dn !== 1 || rn !== 0 || de !== 0) begin
      tests_failed++;
      $display("FAIL clear_seq: busy_cycles=%0d done_pulses=%0d ready_seen=%0d drive_errs=%0d, required 16 1 0 0",
               bn, dn, rn, de);
    end
    for (int i = 0; i < 16; i++) arb_cycle(1'b1, 1'b1, 4'(i), '0, 1'b0, 1'b0, '0, '0, ga, gb);
    idle_cycles(2);
    tests_run++;
    if (sb.size() != 0) begin
      tests_failed++;
      $display("FAIL clear_readback_drain: %0d outstanding, required 0", sb.size());
    end
  endtask

  task automatic test_clear_with_request();
    int bn, dn, rn, de;
    logic rok, gd;
    run_clear(1'b1, -1, -1, -1, bn, dn, rn, de, rok, gd);
    tests_run++;
    if (rn !== 0 || bn !== 16 || dn !== 1) begin
      tests_failed++;
      $display("FAIL clear_req_blocked: ready_seen=%0d busy_cycles=%0d done=%0d, required 0 16 1", rn, bn, dn);
    end
    tests_run++;
    if (gd !== 1'b1) begin
      tests_failed++;
      $display("FAIL clear_req_done_grant: a_ready=%b in clr_done cycle, required 1", gd);
    end
    idle_cycles(1);
  endtask

  task automatic test_clear_ignore_withdraw();
    int bn, dn, rn, de;
    logic rok, gd;
    run_clear(1'b0, 5, 3, -1, bn, dn, rn, de, rok, gd);
    tests_run++;
    if (bn !== 16 || dn !== 1 || rn !== 0 || de !== 0) begin
      tests_failed++;
      $display("FAIL clear_repulse: busy_cycles=%0d done=%0d ready_seen=%0d drive_errs=%0d, required 16 1 0 0",
               bn, dn, rn, de);
    end
    idle_cycles(2);
    tests_run++;
    if (sb.size() != 0) begin
      tests_failed++;
      $display("FAIL clear_withdraw_drain: %0d outstanding, required 0", sb.size());
    end
  endtask

  task automatic test_reset_mid_clear();
    int bn, dn, rn, de;
    logic rok, gd, ga, gb;
    preload(8'hFF);
    run_clear(1'b0, -1, -1, 7, bn, dn, rn, de, rok, gd);
    tests_run++;
    if (rok !== 1'b1) begin
      tests_failed++;
      $display("FAIL rst_mid_clear_outputs: busy=%b ram_cs=%b ready=%b%b, required all 0", busy, ram_cs, a_ready, b_ready);
    end
    tests_run++;
    if (bn !== 7 || dn !== 0) begin
      tests_failed++;
      $display("FAIL rst_mid_clear_seq: busy_cycles=%0d done=%0d, required 7 0", bn, dn);
    end
    for (int i = 0; i < 16; i++) arb_cycle(1'b1, 1'b1, 4'(i), '0, 1'b0, 1'b0, '0, '0, ga, gb);
    idle_cycles(2);
    tests_run++;
    if (m_mem[8] !== 8'hFF || sb.size() != 0) begin
      tests_failed++;
      $display("FAIL rst_mid_clear_drain: %0d outstanding, required 0", sb.size());
    end
  endtask

  initial begin
    rst = 1'b1;
    a_valid = 1'b0; a_rw = 1'b0; a_addr = '0; a_wdata = '0;
    b_valid = 1'b0; b_rw = 1'b0; b_addr = '0; b_wdata = '0;
    clr_start = 1'b0;
    m_pri = 1'b0;
    for (int i = 0; i < 16; i++) m_mem[i] = '0;
    test_reset();
    test_contention();
    test_a_write_read();
    test_b_write_no_rsp();
    test_clear();
    test_clear_with_request();
    test_clear_ignore_withdraw();
    test_reset_mid_clear();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Two-requester access controller for the single-port, synchronous-read generic RAM (`AW` address bits, `DW` data bits; `cs`/`rw`/`addr`/`data_in` in, registered `data_out`). It sits between the RAM and two masters, the CPU (port A) and the loader/debug path (port B). It arbitrates single-word accesses round-robin with a valid/ready handshake and returns read data with a response strobe. It also sequences a full-memory clear on command.

## Interface
- `AW`, 9, RAM address width
- `DW`, 12, RAM data width

Ports:
- `clk`  in  1  single clock, all state on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `a_valid` / `b_valid`  in  1  requester A/B has an access pending
- `a_rw` / `b_rw`  in  1  1 = read, 0 = write (RAM convention)
- `a_addr` / `b_addr`  in  AW  access address
- `a_wdata` / `b_wdata`  in  DW  write data
- `a_ready` / `b_ready`  out  1  grant; access accepted on this rising edge when valid&ready
- `a_rsp_valid` / `b_rsp_valid`  out  1  read data for A/B is on `rsp_rdata` this cycle
- `rsp_rdata`  out  DW  read data, wired to `ram_rdata`
- `clr_start`  in  1  request a full clear (pulse)
- `busy`  out  1  clear in progress
- `clr_done`  out  1  one-cycle pulse after the last clear write
- `ram_cs`, `ram_rw`  out  1  to RAM `cs`/`rw`
- `ram_addr`  out  AW  to RAM `addr`
- `ram_wdata`  out  DW  to RAM `data_in`
- `ram_rdata`  in  DW  from RAM `data_out`

## Operation
- FSM states: IDLE (arbitrate) and CLEAR.
- State registers: `state`, priority pointer `pri` (0 = A favoured), clear counter `cnt[AW-1:0]`, `a_rsp_valid`, `b_rsp_valid`, `clr_done`.
- IDLE, `clr_start`=0:
  - One valid requester: it is granted.
  - Both valid: the requester selected by `pri` is granted.
  - The grant is combinational from the current-cycle inputs.
  - The granted requester's rw/addr/wdata drive the RAM with `ram_cs`=1.
  - No grant: `ram_cs`=0, other RAM outputs don't-care.
  - After any grant, `pri` points to the *other* requester, so contention alternates A, B, A, …
- IDLE, `clr_start`=1:
  - Clear wins: no grant that cycle, `ram_cs`=0.
  - Next state CLEAR, `cnt`←0.
- CLEAR:
  - `a_ready`=`b_ready`=0 and `busy`=1.
  - RAM driven with `ram_cs`=1, `ram_rw`=0, `ram_addr`=`cnt`, `ram_wdata`=0.
  - `cnt` increments each cycle.
  - When `cnt`==2^AW−1: that write completes, then state←IDLE, `cnt`←0, `clr_done`=1 for the next cycle.
  - `clr_start` in CLEAR is ignored and does not restart the sequence.
- Responses are produced only for reads. A granted read sets the matching `*_rsp_valid` for exactly the following cycle. Writes produce no response.
- Requesters hold valid/rw/addr/wdata stable until ready. Dropping valid before ready is legal and means the request is withdrawn.
- `rst` asserted, including mid-clear or mid-read:
  - Immediately: state=IDLE, `pri`=0, `cnt`=0, all rsp_valid/`clr_done`/`busy`=0.
  - While `rst`=1: `a_ready`, `b_ready`, `ram_cs` are forced 0.
  - An aborted clear leaves the RAM partially cleared; no `clr_done`.

## Timing
- Throughput: one RAM access per cycle in IDLE. A single continuously-valid requester is granted every cycle.
- Read latency: request granted at edge N, so `*_rsp_valid`=1 and `rsp_rdata` valid in cycle N+1. `rsp_rdata` is undefined when no rsp_valid is high.
- Back-to-back reads: the response for access N and the RAM drive for access N+1 coexist in the same cycle.
- Clear: `busy` rises the cycle after `clr_start` and stays high for exactly 2^AW cycles. `clr_done` is high in the cycle after `busy` falls. The first arbitration is possible in that same cycle.
- Reset values: all outputs 0; `ram_rw`, `ram_addr`, `ram_wdata` are 0 while `rst`=1.

## Test plan
Bench parameters: AW=4, DW=8, behavioural RAM model with 1-cycle registered read.
- **A-only write then read:** A writes 0x5A to addr 3, then reads addr 3 → `a_ready` high both cycles, `a_rsp_valid`=1 one cycle after the read grant, `rsp_rdata`=0x5A, `b_rsp_valid` stays 0.
- **Contention:** A and B both valid reading addrs 1 and 2 for 4 cycles → grants alternate A, B, A, B starting with A after reset; responses alternate with the matching data.
- **Clear:** preload addrs 0..15 with 0xFF, pulse `clr_start` → `busy` high exactly 16 cycles, ready low throughout, `clr_done` single pulse, readback of all 16 addresses = 0x00.
- **Simultaneous clear and request:** `clr_start`=1 with `a_valid`=1 → no `a_ready` that cycle; A is first granted in the `clr_done` cycle.
- **Clear ignore and reset mid-clear:** `clr_start` re-pulsed at `cnt`=5 → no restart, `busy` still 16 cycles. Separately, `rst` at `cnt`=7 → `busy`, `ram_cs` and readys drop immediately, no `clr_done`, addrs 8..15 retain 0xFF.
- **Withdrawn request / write no response:** B write granted → no `b_rsp_valid`. A raises then drops valid while the clear is running → no grant, no response.
